// File: rtl/operand_fetch.sv
// PDP-11 style operand fetch sequencer: resolves one source operand for
// addressing modes 0-7 against an external register file and a stallable memory port.
module operand_fetch (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mode,
    input  logic [2:0]  rn,
    output logic        busy,
    output logic        done,
    output logic        is_reg,
    output logic [15:0] operand,
    output logic [15:0] ea,
    output logic [2:0]  sela,
    output logic [2:0]  selb,
    output logic        we,
    output logic [15:0] w,
    input  logic [15:0] b,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic        mem_rdy,
    input  logic [15:0] mem_din
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EA,
        S_IDX,
        S_IDXADD,
        S_DEF,
        S_RD,
        S_DONE
    } state_e;

    localparam logic [2:0]  PC_REG = 3'd7;
    localparam logic [15:0] WORD   = 16'd2;

    state_e      state_q, state_d;
    logic [2:0]  mode_q, mode_d;
    logic [2:0]  rn_q, rn_d;
    logic [15:0] x_q, x_d;
    logic [15:0] operand_q, operand_d;
    logic [15:0] ea_q, ea_d;
    logic        is_reg_q, is_reg_d;
    logic        we_raw;
    logic [15:0] w_raw;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            mode_q    <= '0;
            rn_q      <= '0;
            x_q       <= '0;
            operand_q <= '0;
            ea_q      <= '0;
            is_reg_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            rn_q      <= rn_d;
            x_q       <= x_d;
            operand_q <= operand_d;
            ea_q      <= ea_d;
            is_reg_q  <= is_reg_d;
        end
    end

    // NOTE: every output of this block gets a default before the case so
    // that no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        rn_d      = rn_q;
        x_d       = x_q;
        operand_d = operand_q;
        ea_d      = ea_q;
        is_reg_d  = is_reg_q;
        we_raw    = 1'b0;
        w_raw     = '0;
        mem_rd    = 1'b0;
        mem_addr  = '0;
        done      = 1'b0;
        selb      = (state_q == S_IDX) ? PC_REG : rn_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d   = mode;
                    rn_d     = rn;
                    is_reg_d = 1'b0;
                    state_d  = S_EA;
                end
            end
            S_EA: begin
                case (mode_q)
                    3'd0: begin
                        operand_d = b;
                        ea_d      = '0;
                        is_reg_d  = 1'b1;
                        state_d   = S_DONE;
                    end
                    3'd1: begin
                        ea_d    = b;
                        state_d = S_RD;
                    end
                    3'd2, 3'd3: begin
                        ea_d    = b;
                        we_raw  = 1'b1;
                        w_raw   = b + WORD;
                        state_d = (mode_q == 3'd2) ? S_RD : S_DEF;
                    end
                    3'd4, 3'd5: begin
                        ea_d    = b - WORD;
                        we_raw  = 1'b1;
                        w_raw   = b - WORD;
                        state_d = (mode_q == 3'd4) ? S_RD : S_DEF;
                    end
                    default: state_d = S_IDX;
                endcase
            end
            S_IDX: begin
                mem_addr = b;
                mem_rd   = 1'b1;
                if (mem_rdy) begin
                    x_d     = mem_din;
                    we_raw  = 1'b1;
                    w_raw   = b + WORD;
                    state_d = S_IDXADD;
                end
            end
            S_IDXADD: begin
                // b already reflects the PC bump written on leaving IDX.
                ea_d    = b + x_q;
                state_d = (mode_q == 3'd6) ? S_RD : S_DEF;
            end
            S_DEF: begin
                mem_addr = ea_q;
                mem_rd   = 1'b1;
                if (mem_rdy) begin
                    ea_d    = mem_din;
                    state_d = S_RD;
                end
            end
            S_RD: begin
                mem_addr = ea_q;
                mem_rd   = 1'b1;
                if (mem_rdy) begin
                    operand_d = mem_din;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Reset suppresses the register-file write combinationally, in the same cycle.
    assign we      = we_raw & ~reset;
    assign w       = we ? w_raw : '0;
    assign sela    = selb;
    assign busy    = (state_q != S_IDLE);
    assign is_reg  = is_reg_q;
    assign operand = operand_q;
    assign ea      = ea_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: register-file and memory models with
// configurable stall, checking latency, write-back and wrap-around behaviour.
module tb_operand_fetch;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  mode;
    logic [2:0]  rn;
    logic        busy;
    logic        done;
    logic        is_reg;
    logic [15:0] operand;
    logic [15:0] ea;
    logic [2:0]  sela;
    logic [2:0]  selb;
    logic        we;
    logic [15:0] w;
    logic [15:0] b;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_rdy;
    logic [15:0] mem_din;

    operand_fetch dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .rn       (rn),
        .busy     (busy),
        .done     (done),
        .is_reg   (is_reg),
        .operand  (operand),
        .ea       (ea),
        .sela     (sela),
        .selb     (selb),
        .we       (we),
        .w        (w),
        .b        (b),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .mem_rdy  (mem_rdy),
        .mem_din  (mem_din)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file model with a bench-side preload port.
    logic [15:0] rf [0:7];
    logic        pre_we;
    logic [2:0]  pre_idx;
    logic [15:0] pre_val;
    assign b = rf[selb];
    always @(posedge clk) begin
        if (we) rf[selb] <= w;
        else if (pre_we) rf[pre_idx] <= pre_val;
    end

    // Memory model: ready after `stall` waiting cycles, or forced ready.
    logic [15:0] mem [0:65535];
    int          stall;
    int          wait_cnt;
    logic        rdy_force;
    assign mem_din = mem[mem_addr];
    assign mem_rdy = rdy_force | (mem_rd && (wait_cnt >= stall));
    always @(posedge clk) begin
        if (mem_rd && !mem_rdy) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    int   we_cnt;
    logic we_bad;
    initial begin
        we_cnt = 0;
        we_bad = 1'b0;
        wait_cnt = 0;
    end
    always @(posedge clk) if (we) we_cnt <= we_cnt + 1;
    always @(negedge clk) if ((we && reset) || (!we && w != 16'd0)) we_bad <= 1'b1;

    int n_checks;
    int n_fail;
    logic [15:0] addr_log [0:63];
    logic [2:0]  sela_log [0:63];
    logic        rd_log   [0:63];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [2:0] idx, input logic [15:0] val);
        pre_we  = 1'b1;
        pre_idx = idx;
        pre_val = val;
        @(negedge clk);
        pre_we  = 1'b0;
    endtask

    // Issues start at a falling edge; lat = cycle index in which done is seen, -1 on timeout.
    task automatic fetch(input logic [2:0] m, input logic [2:0] r, output int lat, output int we_n);
        int base;
        base  = we_cnt;
        mode  = m;
        rn    = r;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        addr_log[1] = mem_addr; sela_log[1] = sela; rd_log[1] = mem_rd;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            addr_log[lat] = mem_addr; sela_log[lat] = sela; rd_log[lat] = mem_rd;
        end
        if (!done) lat = -1;
        we_n = we_cnt - base;
    endtask

    initial begin
        int lat;
        int we_n;
        int done_seen;
        n_checks  = 0;
        n_fail    = 0;
        pre_we    = 1'b0;
        pre_idx   = '0;
        pre_val   = '0;
        rdy_force = 1'b0;
        stall     = 0;
        for (int i = 0; i < 8; i++) rf[i] = 16'd0;

        // Reset with start held high: start must be ignored.
        reset = 1'b1;
        start = 1'b1;
        mode  = 3'd0;
        rn    = 3'd3;
        repeat (2) @(negedge clk);
        check("rst_busy",   busy,   1'b0);
        check("rst_done",   done,   1'b0);
        check("rst_is_reg", is_reg, 1'b0);
        check("rst_operand", operand, 16'd0);
        check("rst_ea",     ea,     16'd0);
        check("rst_we",     we,     1'b0);
        check("rst_mem_rd", mem_rd, 1'b0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_start_ignored", busy, 1'b0);

        // Mode 0, spurious mem_rdy held high throughout.
        preload(3'd3, 16'o000123);
        rdy_force = 1'b1;
        fetch(3'd0, 3'd3, lat, we_n);
        check("m0_latency", lat, 2);
        check("m0_operand", operand, 16'o000123);
        check("m0_is_reg",  is_reg, 1'b1);
        check("m0_ea",      ea, 16'd0);
        check("m0_we_count", we_n, 0);
        check("m0_sela_ea", sela_log[1], 3'd3);
        check("m0_selb_ea", selb, 3'd3);
        @(negedge clk);
        rdy_force = 1'b0;
        check("m0_done_pulse", done, 1'b0);
        check("m0_idle", busy, 1'b0);
        check("m0_is_reg_hold", is_reg, 1'b1);

        // Mode 2 with a two-cycle memory stall.
        preload(3'd6, 16'o001000);
        mem[16'o001000] = 16'o052525;
        stall = 2;
        fetch(3'd2, 3'd6, lat, we_n);
        stall = 0;
        check("m2_latency", lat, 5);
        check("m2_operand", operand, 16'o052525);
        check("m2_ea", ea, 16'o001000);
        check("m2_is_reg", is_reg, 1'b0);
        check("m2_sp_inc", rf[6], 16'o001002);
        check("m2_we_count", we_n, 1);
        check("m2_stall_addr0", addr_log[2], 16'o001000);
        check("m2_stall_addr1", addr_log[3], 16'o001000);
        check("m2_stall_rd", rd_log[3], 1'b1);
        check("m2_ea_no_rd", rd_log[1], 1'b0);

        // Mode 5: predecrement deferred.
        preload(3'd1, 16'o000004);
        mem[16'o000002] = 16'o002000;
        mem[16'o002000] = 16'o000777;
        fetch(3'd5, 3'd1, lat, we_n);
        check("m5_latency", lat, 4);
        check("m5_operand", operand, 16'o000777);
        check("m5_ea", ea, 16'o002000);
        check("m5_r1_dec", rf[1], 16'o000002);
        check("m5_we_count", we_n, 1);

        // Mode 6 on the PC: PC-relative.
        preload(3'd7, 16'o000100);
        mem[16'o000100] = 16'o000010;
        mem[16'o000112] = 16'o123456;
        fetch(3'd6, 3'd7, lat, we_n);
        check("m6_latency", lat, 5);
        check("m6_operand", operand, 16'o123456);
        check("m6_ea", ea, 16'o000112);
        check("m6_pc_inc", rf[7], 16'o000102);
        check("m6_we_count", we_n, 1);
        check("m6_idx_addr", addr_log[2], 16'o000100);

        // Mode 7 on R1: index word comes from PC, base from R1.
        preload(3'd1, 16'o000200);
        preload(3'd7, 16'o000300);
        mem[16'o000300] = 16'o000004;
        mem[16'o000204] = 16'o003000;
        mem[16'o003000] = 16'o000555;
        fetch(3'd7, 3'd1, lat, we_n);
        check("m7_latency", lat, 6);
        check("m7_operand", operand, 16'o000555);
        check("m7_ea", ea, 16'o003000);
        check("m7_pc_inc", rf[7], 16'o000302);
        check("m7_r1_kept", rf[1], 16'o000200);
        check("m7_sela_ea", sela_log[1], 3'd1);
        check("m7_sela_idx", sela_log[2], 3'd7);
        check("m7_sela_idxadd", sela_log[3], 3'd1);

        // Mode 4 wrap below zero.
        preload(3'd2, 16'o000000);
        mem[16'o177776] = 16'o011111;
        fetch(3'd4, 3'd2, lat, we_n);
        check("m4_latency", lat, 3);
        check("m4_r2_wrap", rf[2], 16'o177776);
        check("m4_ea", ea, 16'o177776);
        check("m4_operand", operand, 16'o011111);

        // Mode 2 wrap above 177776.
        preload(3'd5, 16'o177776);
        fetch(3'd2, 3'd5, lat, we_n);
        check("m2w_latency", lat, 3);
        check("m2w_r5_wrap", rf[5], 16'o000000);
        check("m2w_ea", ea, 16'o177776);

        // Mode 1: deferred register, no write-back.
        preload(3'd4, 16'o000500);
        mem[16'o000500] = 16'o000042;
        fetch(3'd1, 3'd4, lat, we_n);
        check("m1_latency", lat, 3);
        check("m1_operand", operand, 16'o000042);
        check("m1_r4_kept", rf[4], 16'o000500);
        check("m1_we_count", we_n, 0);

        // Mode 3 aborted by reset while stalled in DEF.
        preload(3'd0, 16'o001000);
        mem[16'o001000] = 16'o002000;
        mem[16'o002000] = 16'o000007;
        stall = 3;
        mode  = 3'd3;
        rn    = 3'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("abort_in_def_rd", mem_rd, 1'b1);
        check("abort_def_addr", mem_addr, 16'o001000);
        reset = 1'b1;
        check("abort_we_in_reset", we, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        stall = 0;
        check("abort_busy", busy, 1'b0);
        check("abort_mem_rd", mem_rd, 1'b0);
        check("abort_ea", ea, 16'd0);
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        check("abort_r0_inc", rf[0], 16'o001002);
        fetch(3'd0, 3'd0, lat, we_n);
        check("after_abort_latency", lat, 2);
        check("after_abort_operand", operand, 16'o001002);
        check("after_abort_is_reg", is_reg, 1'b1);

        @(negedge clk);
        check("we_rules", we_bad, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
